matrix_scan_driver: RTL and testbench

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

---
 rtl/matrix_pkg.sv | 15 +
 rtl/scan_counter.sv | 51 +++++
 rtl/matrix_scan_driver.sv | 112 +++++++++++
 tb/tb_matrix_scan_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the LED matrix scan driver.
package matrix_pkg;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_DWELL = 16;
    localparam int DEF_BLANK = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BLANKING = 2'd1,
        ON       = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_counter.sv
// Row/tick scan counter. Exposes the slot the next edge will display so the
// driver can register its outputs against that slot on the same edge.
module scan_counter #(
    parameter int ROWS  = 8,
    parameter int DWELL = 16,
    localparam int RW   = $clog2(ROWS),
    localparam int TW   = $clog2(DWELL)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          OE,
    input  logic          restart,
    output logic [RW-1:0] r_nxt,
    output logic [TW-1:0] t_nxt,
    output logic          frame_end
);

    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(DWELL - 1);

    logic [RW-1:0] r_q;
    logic [TW-1:0] t_q;

    // Next slot: cleared while disabled, slot 0 on the first enabled edge, else advance with wrap.
    always_comb begin
        frame_end = (r_q == R_LAST) && (t_q == T_LAST);
        r_nxt     = r_q;
        t_nxt     = t_q;
        if (!OE || restart) begin
            r_nxt = '0;
            t_nxt = '0;
        end else if (t_q == T_LAST) begin
            t_nxt = '0;
            r_nxt = (r_q == R_LAST) ? '0 : r_q + RW'(1);
        end else begin
            t_nxt = t_q + TW'(1);
        end
    end

    // Slot registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
            t_q <= '0;
        end else begin
            r_q <= r_nxt;
            t_q <= t_nxt;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// Multiplexed LED matrix scan driver with shadowed frame/brightness and a
// LOAD/ACK handshake that only swaps the shadow between frames or while idle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | OE low: rows and columns off, CLEAR high, counters held at 0
// BLANKING | t < BLANK: anti-ghost gap, row and columns off
// ON       | t >= BLANK: row r selected, columns lit inside on-window
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DWELL = DEF_DWELL,
    parameter int BLANK = DEF_BLANK,
    localparam int BW   = $clog2(DWELL + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 OE,
    input  logic [ROWS*COLS-1:0] DATA,
    input  logic [BW-1:0]        BRIGHT,
    input  logic                 LOAD,
    output logic                 ACK,
    output logic [ROWS-1:0]      ROW,
    output logic [COLS-1:0]      COLUMN,
    output logic                 CLEAR
);

    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(DWELL);
    localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
    localparam logic [BW:0]   BLANK_W = (BW + 1)'(BLANK);

    scan_state_t state_q, state_d;

    logic [RW-1:0]        r_nxt;
    logic [TW-1:0]        t_nxt;
    logic                 frame_end;
    logic                 capture;
    logic [ROWS*COLS-1:0] shadow_q, shadow_d;
    logic [BW-1:0]        bright_q, bright_d;
    logic [BW:0]          t_ext, on_end;
    logic [ROWS-1:0]      row_d;
    logic [COLS-1:0]      col_d;
    logic                 clear_d;

    scan_counter #(
        .ROWS  (ROWS),
        .DWELL (DWELL)
    ) u_scan_counter (
        .CLK       (CLK),
        .RST       (RST),
        .OE        (OE),
        .restart   (state_q == IDLE),
        .r_nxt     (r_nxt),
        .t_nxt     (t_nxt),
        .frame_end (frame_end)
    );

    // Capture only between frames or while idle; the ACK cycle masks a still-high LOAD.
    always_comb begin
        capture  = LOAD && !ACK && (frame_end || (state_q == IDLE));
        shadow_d = capture ? DATA   : shadow_q;
        bright_d = capture ? BRIGHT : bright_q;
    end

    // Next state and output decode for the slot being entered; the on-window
    // naturally saturates because t never exceeds DWELL-1.
    always_comb begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
        clear_d = 1'b1;
        t_ext   = (BW + 1)'(t_nxt);
        on_end  = BLANK_W + {1'b0, bright_d};
        if (OE) begin
            clear_d = (r_nxt == R_LAST);
            if (t_ext < BLANK_W) begin
                state_d = BLANKING;
            end else begin
                state_d = ON;
                row_d   = ROWS'(1) << r_nxt;
                if (t_ext < on_end) begin
                    col_d = shadow_d[r_nxt*COLS +: COLS];
                end
            end
        end
    end

    // State, shadow and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            bright_q <= BW'(DWELL);
            ACK      <= 1'b0;
            ROW      <= '0;
            COLUMN   <= '0;
            CLEAR    <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bright_q <= bright_d;
            ACK      <= capture;
            ROW      <= row_d;
            COLUMN   <= col_d;
            CLEAR    <= clear_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver at default parameters.
module tb_matrix_scan_driver;

    localparam logic [63:0] FRAME_A = 64'h8040201008040201;
    localparam logic [63:0] FRAME_B = 64'h0102040810204080;

    logic        CLK;
    logic        RST;
    logic        OE;
    logic [63:0] DATA;
    logic [4:0]  BRIGHT;
    logic        LOAD;
    logic        ACK;
    logic [7:0]  ROW;
    logic [7:0]  COLUMN;
    logic        CLEAR;

    int checks   = 0;
    int failures = 0;

    matrix_scan_driver dut (
        .CLK    (CLK),
        .RST    (RST),
        .OE     (OE),
        .DATA   (DATA),
        .BRIGHT (BRIGHT),
        .LOAD   (LOAD),
        .ACK    (ACK),
        .ROW    (ROW),
        .COLUMN (COLUMN),
        .CLEAR  (CLEAR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected ROW n edges after OE rose (16-cycle slots, 2 blank cycles).
    function automatic logic [7:0] exp_row(int n);
        int t = n % 16;
        int r = (n / 16) % 8;
        if (t < 2) return 8'h00;
        return 8'(1 << r);
    endfunction

    function automatic logic [7:0] exp_col(logic [63:0] d, int br, int n);
        int t = n % 16;
        int r = (n / 16) % 8;
        if (t >= 2 && t < 2 + br) return d[r*8 +: 8];
        return 8'h00;
    endfunction

    task automatic test_reset();
        RST = 1'b1; OE = 1'b1; LOAD = 1'b1; DATA = '1; BRIGHT = 5'd16;
        step();
        step();
        checks++; if (ROW !== 8'h00) begin failures++; $display("FAIL reset_row got=%h exp=00", ROW); end
        checks++; if (COLUMN !== 8'h00) begin failures++; $display("FAIL reset_col got=%h exp=00", COLUMN); end
        checks++; if (CLEAR !== 1'b1) begin failures++; $display("FAIL reset_clear got=%b exp=1", CLEAR); end
        checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ACK); end
        RST = 1'b0; LOAD = 1'b0; OE = 1'b0; DATA = '0;
        step();
        checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL reset_no_ack got=%b exp=0", ACK); end
    endtask

    task automatic test_scan_default();
        OE = 1'b1;
        for (int n = 0; n < 128; n++) begin
            step();
            checks++; if (ROW !== exp_row(n)) begin failures++; $display("FAIL scan_row n=%0d got=%h exp=%h", n, ROW, exp_row(n)); end
            checks++; if (CLEAR !== (n >= 112)) begin failures++; $display("FAIL scan_clear n=%0d got=%b", n, CLEAR); end
            checks++; if (COLUMN !== 8'h00) begin failures++; $display("FAIL scan_col n=%0d got=%h exp=00", n, COLUMN); end
        end
        OE = 1'b0;
        step();
    endtask

    task automatic test_load_idle();
        step();
        checks++; if (ROW !== 8'h00 || CLEAR !== 1'b1) begin failures++; $display("FAIL idle_out row=%h clear=%b", ROW, CLEAR); end
        DATA = FRAME_A; BRIGHT = 5'd16; LOAD = 1'b1;
        step();
        checks++; if (ACK !== 1'b1) begin failures++; $display("FAIL idle_ack got=%b exp=1", ACK); end
        DATA = '1;
        step();
        checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL idle_ack_once got=%b exp=0", ACK); end
        LOAD = 1'b0;
        OE = 1'b1;
        for (int n = 0; n < 128; n++) begin
            step();
            checks++; if (COLUMN !== exp_col(FRAME_A, 16, n)) begin failures++; $display("FAIL idle_col n=%0d got=%h exp=%h", n, COLUMN, exp_col(FRAME_A, 16, n)); end
        end
        OE = 1'b0;
        step();
    endtask

    task automatic test_bright();
        int brs[3] = '{4, 0, 16};
        foreach (brs[i]) begin
            DATA = FRAME_A; BRIGHT = 5'(brs[i]); LOAD = 1'b1;
            step();
            checks++; if (ACK !== 1'b1) begin failures++; $display("FAIL bright_ack br=%0d got=%b", brs[i], ACK); end
            LOAD = 1'b0;
            step();
            OE = 1'b1;
            for (int n = 0; n < 128; n++) begin
                step();
                checks++; if (ROW !== exp_row(n)) begin failures++; $display("FAIL bright_row br=%0d n=%0d got=%h exp=%h", brs[i], n, ROW, exp_row(n)); end
                checks++; if (COLUMN !== exp_col(FRAME_A, brs[i], n)) begin failures++; $display("FAIL bright_col br=%0d n=%0d got=%h exp=%h", brs[i], n, COLUMN, exp_col(FRAME_A, brs[i], n)); end
            end
            OE = 1'b0;
            step();
        end
    endtask

    task automatic test_midframe_load();
        DATA = FRAME_A; BRIGHT = 5'd16; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        step();
        OE = 1'b1;
        for (int n = 0; n < 256; n++) begin
            step();
            checks++; if (ACK !== (n == 128)) begin failures++; $display("FAIL mid_ack n=%0d got=%b", n, ACK); end
            checks++; if (COLUMN !== exp_col((n >= 128) ? FRAME_B : FRAME_A, 16, n)) begin
                failures++; $display("FAIL mid_col n=%0d got=%h exp=%h", n, COLUMN, exp_col((n >= 128) ? FRAME_B : FRAME_A, 16, n));
            end
            if (n == 53) begin LOAD = 1'b1; DATA = FRAME_B; end
            if (n == 128) LOAD = 1'b0;
        end
        OE = 1'b0;
        step();
    endtask

    task automatic test_oe_drop();
        OE = 1'b1;
        for (int n = 0; n < 88; n++) step();
        checks++; if (ROW !== 8'h20 || COLUMN !== 8'h04) begin failures++; $display("FAIL drop_pre row=%h col=%h exp=20/04", ROW, COLUMN); end
        OE = 1'b0;
        step();
        checks++; if (ROW !== 8'h00 || COLUMN !== 8'h00 || CLEAR !== 1'b1) begin
            failures++; $display("FAIL drop_idle row=%h col=%h clear=%b", ROW, COLUMN, CLEAR);
        end
        OE = 1'b1;
        step();
        step();
        checks++; if (ROW !== 8'h00) begin failures++; $display("FAIL drop_blank got=%h exp=00", ROW); end
        step();
        checks++; if (ROW !== 8'h01 || COLUMN !== 8'h80) begin failures++; $display("FAIL drop_restart row=%h col=%h exp=01/80", ROW, COLUMN); end
        OE = 1'b0;
        step();
    endtask

    task automatic test_oe_fall_boundary();
        OE = 1'b1;
        for (int n = 0; n < 128; n++) step();
        LOAD = 1'b1; DATA = FRAME_A; OE = 1'b0;
        step();
        checks++; if (ACK !== 1'b1 || ROW !== 8'h00 || CLEAR !== 1'b1) begin
            failures++; $display("FAIL bnd_capture ack=%b row=%h clear=%b exp=1/00/1", ACK, ROW, CLEAR);
        end
        DATA = '1;
        step();
        checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL bnd_ack_once got=%b exp=0", ACK); end
        LOAD = 1'b0;
        step();
        OE = 1'b1;
        step(); step(); step();
        checks++; if (ROW !== 8'h01 || COLUMN !== 8'h01) begin failures++; $display("FAIL bnd_shadow row=%h col=%h exp=01/01", ROW, COLUMN); end
        OE = 1'b0;
        step();
    endtask

    task automatic test_reset_midframe();
        OE = 1'b1;
        for (int n = 0; n < 40; n++) step();
        LOAD = 1'b1; DATA = FRAME_B;
        step();
        RST = 1'b1;
        step();
        checks++; if (ROW !== 8'h00 || COLUMN !== 8'h00 || CLEAR !== 1'b1 || ACK !== 1'b0) begin
            failures++; $display("FAIL rstmid_out row=%h col=%h clear=%b ack=%b", ROW, COLUMN, CLEAR, ACK);
        end
        RST = 1'b0; LOAD = 1'b0;
        step(); step(); step();
        checks++; if (ROW !== 8'h01 || COLUMN !== 8'h00 || ACK !== 1'b0) begin
            failures++; $display("FAIL rstmid_shadow row=%h col=%h ack=%b exp=01/00/0", ROW, COLUMN, ACK);
        end
        OE = 1'b0;
        step();
    endtask

    initial begin
        RST = 1'b1; OE = 1'b0; LOAD = 1'b0; DATA = '0; BRIGHT = '0;
        test_reset();
        test_scan_default();
        test_load_idle();
        test_bright();
        test_midframe_load();
        test_oe_drop();
        test_oe_fall_boundary();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
